mcu_core_p: RTL
===============

# mcu_core_p

Parametrised successor to the 8-bit accumulator microcontroller core: a multicycle LOAD/FETCH/DECODE/EXECUTE machine with configurable data width, program depth and data depth. It adds three things the previous core lacks: a valid/ready program-loader stream in place of a file preload, a HALT state, and a handshaked output port. It sits at the top of the processor hierarchy and contains its own program memory, data memory, ALU, accumulator and status register.

## Interface
Parameters:
- DW, 8: data/accumulator width; instruction operand width.
- AW, 8: PC width; program memory depth is 2^AW.
- DAW, 4: data memory address width; depth is 2^DAW.
- IW, 4+DW (derived, not overridable): instruction width. Opcode is [IW-1:IW-4]; operand is [DW-1:0].

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- load_valid  in  1  loader word valid.
- load_ready  out  1  core accepts a loader word; high only in LOAD.
- load_data  in  IW  instruction word.
- load_last  in  1  marks the final word of the program.
- prog_len  out  AW+1  number of words loaded.
- out_valid  out  1  one-cycle pulse per OUT instruction.
- out_data  out  DW  Acc value captured by OUT.
- halted  out  1  core is in HALT.
- state  out  3  LOAD=0, FETCH=1, DECODE=2, EXECUTE=3, HALT=4.

## Operation
- Status register SR: [3]=Z, [2]=C, [1]=S, [0]=O.
- LOAD: each cycle with load_valid&&load_ready writes load_data to PMem[prog_len] and increments prog_len.
  - Exits to FETCH after the word carrying load_last is accepted, or after the word at address 2^AW-1 is accepted.
  - The same edge clears PC, Acc, SR, IR and DR.
- FETCH: if PC >= prog_len, go to HALT. Otherwise IR <= PMem[PC] and go to DECODE.
- DECODE: DR <= DMem[operand[DAW-1:0]] (synchronous read); go to EXECUTE.
- EXECUTE: perform the opcode, then go to FETCH. PC <= PC+1 (mod 2^AW) unless a branch is taken.
- HALT: stays in HALT until rst; load_ready=0.
- Opcodes (imm = operand; m = DR):
  - 0: NOP.
  - 1: LDI, Acc<=imm.
  - 2: LD, Acc<=m.
  - 3: ST, DMem[addr]<=Acc.
  - 4: ADD m.
  - 5: ADDI imm.
  - 6: SUB m.
  - 7: AND m.
  - 8: OR m.
  - 9: XOR m.
  - A: JMP, PC<=imm[AW-1:0] (zero-extended if AW>DW).
  - B: JZ, jump if Z.
  - C: JC, jump if C.
  - D: OUT.
  - E: NOP.
  - F: HALT.
- Flags:
  - ADD/ADDI/SUB update all four. Results are DW-bit and wrap.
  - C = carry-out for add. For SUB, C = 1 when Acc < m (borrow).
  - O = signed overflow; S = result MSB; Z = result==0.
  - AND/OR/XOR update Z and S; C and O are cleared.
  - LDI/LD update Z and S; C and O are unchanged.
  - All other opcodes leave SR unchanged.
- OUT: out_data <= Acc and out_valid <= 1 on the EXECUTE edge. out_data holds its value until the next OUT.
- DMem and PMem contents are not cleared by rst.

## Timing
- Reset values:
  - state=LOAD, prog_len=0, PC=0, Acc=0, SR=0.
  - out_valid=0, out_data=0, halted=0.
  - load_ready=1 from the first cycle after rst deasserts.
- rst asserted in any state, including mid-load or mid-instruction: the next edge applies the reset values. A pending ST in that EXECUTE cycle is not performed.
- Loader: one word per cycle at full throughput. Gaps in load_valid are allowed. load_ready drops in the cycle after the terminating word is accepted.
- Each instruction takes exactly 3 cycles (FETCH, DECODE, EXECUTE). The first FETCH is the cycle after the final load handshake.
- out_valid is high for exactly the one cycle following OUT's EXECUTE, which is the next FETCH or HALT cycle.
- FETCH to HALT takes one edge. halted is high from the cycle the state becomes HALT.
- A ST followed immediately by a LD of the same address returns the stored value: the ST write edge precedes the LD's DECODE read.
- JMP to an address >= prog_len leads to HALT at the next FETCH.

## Test plan
- Load with gaps: 3 words, load_valid low for 2 cycles between words 1 and 2, load_last on word 3 -> prog_len=3; load_ready=0 and state=FETCH in the cycle after the third handshake.
- Basic program: LDI 5; ADDI 3; OUT; HALT -> single out_valid pulse with out_data=0x08 exactly 9 cycles after the first FETCH; halted=1 3 cycles later.
- Flags at DW=8:
  - LDI 0xFF; ADDI 1 -> Acc=0x00, SR=1100.
  - LDI 0x7F; ADDI 1 -> Acc=0x80, SR=0011.
  - LDI 0x03; ST 2; LDI 0x01; SUB 2 -> Acc=0xFE, SR=0110.
- Memory: LDI 0x2A; ST 3; LDI 0; LD 3; OUT -> out_data=0x2A. Then run off the end of the program -> HALT with no further out_valid.
- Loop: countdown from 3 using SUB and JZ, with OUT each iteration -> out_data sequence 2, 1, 0 then halted. Repeat with DW=16, AW=10, DAW=6 and a JMP across address 0x200.
- Reset mid-operation: assert rst during EXECUTE of a ST -> target DMem word unchanged, state=LOAD, Acc=0, out_valid=0. Reload a program -> it runs normally.

Source files
------------

// File: rtl/mcu_core_p.sv
// mcu_core_p: multicycle accumulator microcontroller core.
//
// The core first accepts a program over a valid/ready loader stream into its
// program memory (LOAD). It then runs each instruction in three cycles:
// FETCH, DECODE and EXECUTE. It stops in HALT on a HALT opcode, or when the PC
// runs past the loaded program. It leaves HALT only on rst.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   load_valid  loader word valid
//   load_ready  loader word accepted this cycle (high only in LOAD)
//   load_data   instruction word: opcode [DW+3:DW], operand [DW-1:0]
//   load_last   final word of the program
//   prog_len    number of words loaded
//   out_valid   one-cycle pulse after each OUT instruction
//   out_data    accumulator value captured by the most recent OUT
//   halted      core is in HALT
//   state       LOAD=0, FETCH=1, DECODE=2, EXECUTE=3, HALT=4
module mcu_core_p #(
    parameter int DW  = 8,
    parameter int AW  = 8,
    parameter int DAW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [DW+3:0] load_data,
    input  logic          load_last,
    output logic [AW:0]   prog_len,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          halted,
    output logic [2:0]    state
);
    localparam int IW     = DW + 4;
    localparam int PDEPTH = 1 << AW;
    localparam int DDEPTH = 1 << DAW;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_e;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_e        state_q, state_d;
    logic [AW:0]   prog_len_q, prog_len_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [3:0]    sr_q, sr_d;            // {Z, C, S, O}
    logic [IW-1:0] ir_q, ir_d;
    logic [DW-1:0] dr_q, dr_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          load_ready_q, load_ready_d;
    logic          halted_q, halted_d;

    logic [IW-1:0] pmem_q [PDEPTH];
    logic [DW-1:0] dmem_q [DDEPTH];

    logic          pmem_we_s;
    logic          dmem_we_s;
    logic [3:0]    opcode_s;
    logic [DW-1:0] imm_s;
    logic [DAW-1:0] daddr_s;
    logic [AW-1:0] jump_tgt_s;
    logic [AW-1:0] pc_next_s;
    logic [DW-1:0] alu_b_s;
    logic [DW-1:0] add_r_s;
    logic          add_c_s;
    logic          add_o_s;
    logic [DW-1:0] sub_r_s;
    logic          sub_c_s;
    logic          sub_o_s;

    // Builds {Z, C, S, O} from a result plus the carry/overflow to record.
    function automatic logic [3:0] make_flags(input logic [DW-1:0] r,
                                              input logic c, input logic o);
        return {(r == {DW{1'b0}}), c, r[DW-1], o};
    endfunction

    assign opcode_s   = ir_q[IW-1:IW-4];
    assign imm_s      = ir_q[DW-1:0];
    assign daddr_s    = ir_q[DAW-1:0];
    // Size cast truncates or zero-extends the operand to the PC width.
    assign jump_tgt_s = AW'(imm_s);
    assign pc_next_s  = pc_q + AW'(1);

    // ALU datapath: adder (register or immediate operand) and subtractor.
    always_comb begin
        alu_b_s            = (opcode_s == OP_ADDI) ? imm_s : dr_q;
        {add_c_s, add_r_s} = {1'b0, acc_q} + {1'b0, alu_b_s};
        // Signed overflow: operands agree in sign but the result does not.
        add_o_s            = (acc_q[DW-1] == alu_b_s[DW-1]) && (add_r_s[DW-1] != acc_q[DW-1]);
        sub_r_s            = acc_q - dr_q;
        sub_c_s            = (acc_q < dr_q);
        // Signed overflow on subtract: operand signs differ and the result flips.
        sub_o_s            = (acc_q[DW-1] != dr_q[DW-1]) && (sub_r_s[DW-1] != acc_q[DW-1]);
    end

    // Next-state and datapath control for the LOAD/FETCH/DECODE/EXECUTE/HALT machine.
    always_comb begin
        state_d     = state_q;
        prog_len_d  = prog_len_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        sr_d        = sr_q;
        ir_d        = ir_q;
        dr_d        = dr_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        pmem_we_s   = 1'b0;
        dmem_we_s   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (load_valid) begin
                    pmem_we_s  = 1'b1;
                    prog_len_d = prog_len_q + (AW+1)'(1);
                    // Leave on the last word, or once the top PMem address is filled.
                    if (load_last || (prog_len_q[AW-1:0] == {AW{1'b1}})) begin
                        state_d = S_FETCH;
                        pc_d    = {AW{1'b0}};
                        acc_d   = {DW{1'b0}};
                        sr_d    = 4'h0;
                        ir_d    = {IW{1'b0}};
                        dr_d    = {DW{1'b0}};
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_FETCH: begin
                if ({1'b0, pc_q} >= prog_len_q) begin
                    state_d = S_HALT;
                end else begin
                    ir_d    = pmem_q[pc_q];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                dr_d    = dmem_q[daddr_s];
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                pc_d    = pc_next_s;
                case (opcode_s)
                    OP_LDI: begin
                        acc_d = imm_s;
                        sr_d  = make_flags(imm_s, sr_q[2], sr_q[0]);
                    end
                    OP_LD: begin
                        acc_d = dr_q;
                        sr_d  = make_flags(dr_q, sr_q[2], sr_q[0]);
                    end
                    OP_ST: begin
                        dmem_we_s = 1'b1;
                    end
                    OP_ADD, OP_ADDI: begin
                        acc_d = add_r_s;
                        sr_d  = make_flags(add_r_s, add_c_s, add_o_s);
                    end
                    OP_SUB: begin
                        acc_d = sub_r_s;
                        sr_d  = make_flags(sub_r_s, sub_c_s, sub_o_s);
                    end
                    OP_AND: begin
                        acc_d = acc_q & dr_q;
                        sr_d  = make_flags(acc_q & dr_q, 1'b0, 1'b0);
                    end
                    OP_OR: begin
                        acc_d = acc_q | dr_q;
                        sr_d  = make_flags(acc_q | dr_q, 1'b0, 1'b0);
                    end
                    OP_XOR: begin
                        acc_d = acc_q ^ dr_q;
                        sr_d  = make_flags(acc_q ^ dr_q, 1'b0, 1'b0);
                    end
                    OP_JMP: begin
                        pc_d = jump_tgt_s;
                    end
                    OP_JZ: begin
                        if (sr_q[3]) begin
                            pc_d = jump_tgt_s;
                        end else begin
                            pc_d = pc_next_s;
                        end
                    end
                    OP_JC: begin
                        if (sr_q[2]) begin
                            pc_d = jump_tgt_s;
                        end else begin
                            pc_d = pc_next_s;
                        end
                    end
                    OP_OUT: begin
                        out_valid_d = 1'b1;
                        out_data_d  = acc_q;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        acc_d = acc_q;
                    end
                endcase
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        load_ready_d = (state_d == S_LOAD);
        halted_d     = (state_d == S_HALT);
    end

    // Core state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOAD;
            prog_len_q   <= {(AW+1){1'b0}};
            pc_q         <= {AW{1'b0}};
            acc_q        <= {DW{1'b0}};
            sr_q         <= 4'h0;
            ir_q         <= {IW{1'b0}};
            dr_q         <= {DW{1'b0}};
            out_valid_q  <= 1'b0;
            out_data_q   <= {DW{1'b0}};
            load_ready_q <= 1'b1;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            prog_len_q   <= prog_len_d;
            pc_q         <= pc_d;
            acc_q        <= acc_d;
            sr_q         <= sr_d;
            ir_q         <= ir_d;
            dr_q         <= dr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            load_ready_q <= load_ready_d;
            halted_q     <= halted_d;
        end
    end

    // Program and data memory writes; contents survive reset, but a write in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst && pmem_we_s) begin
            pmem_q[prog_len_q[AW-1:0]] <= load_data;
        end
        if (!rst && dmem_we_s) begin
            dmem_q[daddr_s] <= acc_q;
        end
    end

    assign load_ready = load_ready_q;
    assign prog_len   = prog_len_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign halted     = halted_q;
    assign state      = state_q;

endmodule
